// File: rtl/pipeline_m_stage.sv
// MIPS memory stage: E/M pipeline register, byte-enabled word data memory,
// store-data forwarding mux and load alignment/extension.
module pipeline_m_stage #(
  parameter int DM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_E,
  input  logic [31:0] ALUOutput_E,
  input  logic [31:0] WriteData_E,
  input  logic [4:0]  WriteRd_E,
  input  logic [31:0] PCPlus4_E,
  input  logic [31:0] MUXRFWDOut,
  input  logic        ForwardRTM,
  output logic [31:0] Instr_M,
  output logic [31:0] ALUOutput_M,
  output logic [4:0]  WriteRd_M,
  output logic [31:0] PCPlus4_M,
  output logic [31:0] ReadData_M,
  output logic        MemWrite_M
);
  localparam int AW = $clog2(DM_DEPTH);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0] Instr_q, ALUOutput_q, WriteData_q, PCPlus4_q;
  logic [4:0]  WriteRd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instr_q     <= '0;
      ALUOutput_q <= '0;
      WriteData_q <= '0;
      WriteRd_q   <= '0;
      PCPlus4_q   <= '0;
    end else begin
      Instr_q     <= Instr_E;
      ALUOutput_q <= ALUOutput_E;
      WriteData_q <= WriteData_E;
      WriteRd_q   <= WriteRd_E;
      PCPlus4_q   <= PCPlus4_E;
    end
  end

  assign Instr_M     = Instr_q;
  assign ALUOutput_M = ALUOutput_q;
  assign WriteRd_M   = WriteRd_q;
  assign PCPlus4_M   = PCPlus4_q;

  logic [5:0]    op;
  logic [1:0]    boff;
  logic [AW-1:0] idx;
  logic [31:0]   sd, wdata, word;
  logic [3:0]    be;
  logic [15:0]   hsel;
  logic [7:0]    bsel;

  assign op   = Instr_q[31:26];
  assign boff = ALUOutput_q[1:0];
  assign idx  = ALUOutput_q[AW+1:2];
  assign sd   = ForwardRTM ? MUXRFWDOut : WriteData_q;

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be    = 4'b0000;
    wdata = sd;
    case (op)
      OP_SW: be = 4'b1111;
      OP_SH: begin
        be    = boff[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sd[15:0]}};
      end
      OP_SB: begin
        be    = 4'b0001 << boff;
        wdata = {4{sd[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  assign MemWrite_M = |be;

  // Contents deliberately survive reset.
  logic [31:0] mem [DM_DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end

  assign word = mem[idx];
  assign hsel = boff[1] ? word[31:16] : word[15:0];
  assign bsel = word[8*boff +: 8];

  always_comb begin
    ReadData_M = '0;
    case (op)
      OP_LW:  ReadData_M = word;
      OP_LH:  ReadData_M = {{16{hsel[15]}}, hsel};
      OP_LHU: ReadData_M = {16'h0, hsel};
      OP_LB:  ReadData_M = {{24{bsel[7]}}, bsel};
      OP_LBU: ReadData_M = {24'h0, bsel};
      default: ReadData_M = '0;
    endcase
  end
endmodule

// File: tb/tb_pipeline_m_stage.sv
// Directed bench for pipeline_m_stage: table of load/store vectors plus
// hand-written reset sequences.
module tb_pipeline_m_stage;
  logic        clk, reset;
  logic [31:0] Instr_E, ALUOutput_E, WriteData_E, PCPlus4_E, MUXRFWDOut;
  logic [4:0]  WriteRd_E;
  logic        ForwardRTM;
  logic [31:0] Instr_M, ALUOutput_M, PCPlus4_M, ReadData_M;
  logic [4:0]  WriteRd_M;
  logic        MemWrite_M;

  int checks = 0;
  int errors = 0;

  pipeline_m_stage #(.DM_DEPTH(1024)) dut (
    .clk(clk), .reset(reset),
    .Instr_E(Instr_E), .ALUOutput_E(ALUOutput_E), .WriteData_E(WriteData_E),
    .WriteRd_E(WriteRd_E), .PCPlus4_E(PCPlus4_E), .MUXRFWDOut(MUXRFWDOut),
    .ForwardRTM(ForwardRTM),
    .Instr_M(Instr_M), .ALUOutput_M(ALUOutput_M), .WriteRd_M(WriteRd_M),
    .PCPlus4_M(PCPlus4_M), .ReadData_M(ReadData_M), .MemWrite_M(MemWrite_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101,
                         LB = 6'b100000, LBU = 6'b100100, SW = 6'b101011,
                         SH = 6'b101001, SB = 6'b101000, ALU = 6'b000000;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        fwd;
    logic [31:0] mux;
    logic [31:0] exp_rd;
    logic        exp_mw;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [31:0] mk(input logic [5:0] op, input int n);
    return {op, 5'd1, 5'd9, n[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input logic fwd, input logic [31:0] mux, input logic [31:0] exp_rd,
                     input logic exp_mw);
    vec_t v;
    v.op = op; v.addr = addr; v.wd = wd; v.fwd = fwd; v.mux = mux;
    v.exp_rd = exp_rd; v.exp_mw = exp_mw;
    vecs.push_back(v);
  endtask

  task automatic drive_e(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc4);
    Instr_E = instr; ALUOutput_E = addr; WriteData_E = wd; WriteRd_E = rd; PCPlus4_E = pc4;
  endtask

  initial begin
    logic [31:0] instr;
    reset = 1'b0;
    ForwardRTM = 1'b0;
    MUXRFWDOut = '0;
    drive_e('0, '0, '0, '0, '0);

    // Held in reset with random E traffic: everything stays cleared.
    for (int i = 0; i < 3; i++) begin
      drive_e($urandom, $urandom, $urandom, 5'($urandom), $urandom);
      Instr_E[31:26] = SW;
      @(posedge clk); #1;
      chk("rst_instr", Instr_M, 32'h0);
      chk("rst_alu", ALUOutput_M, 32'h0);
      chk("rst_rd", {27'h0, WriteRd_M}, 32'h0);
      chk("rst_pc4", PCPlus4_M, 32'h0);
      chk("rst_rdata", ReadData_M, 32'h0);
      chk("rst_mw", {31'h0, MemWrite_M}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    drive_e(mk(SW, 'h40), 32'h40, 32'h0BADF00D, 5'd3, 32'h104);
    @(posedge clk); #1;
    chk("post_rst_mw", {31'h0, MemWrite_M}, 32'h1);
    chk("post_rst_instr", Instr_M, mk(SW, 'h40));

    add(SW,  32'h10,   32'h8899AABB, 0, 0, 32'h0,        1);
    add(LW,  32'h10,   32'h0,        0, 0, 32'h8899AABB, 0);
    add(LB,  32'h13,   32'h0,        0, 0, 32'hFFFFFF88, 0);
    add(LBU, 32'h11,   32'h0,        0, 0, 32'h000000AA, 0);
    add(SW,  32'h10,   32'hFFFFFFFF, 0, 0, 32'h0,        1);
    add(SH,  32'h12,   32'h00001234, 0, 0, 32'h0,        1);
    add(LW,  32'h10,   32'h0,        0, 0, 32'h1234FFFF, 0);
    add(LH,  32'h12,   32'h0,        0, 0, 32'h00001234, 0);
    add(SB,  32'h10,   32'h0000007F, 0, 0, 32'h0,        1);
    add(LW,  32'h10,   32'h0,        0, 0, 32'h1234FF7F, 0);
    add(LHU, 32'h10,   32'h0,        0, 0, 32'h0000FF7F, 0);
    add(LH,  32'h11,   32'h0,        0, 0, 32'hFFFFFF7F, 0);
    add(SW,  32'h20,   32'h11111111, 1, 32'hCAFEBABE, 32'h0, 1);
    add(LW,  32'h20,   32'h0,        0, 0, 32'hCAFEBABE, 0);
    add(SW,  32'h1000, 32'hDEADBEEF, 0, 0, 32'h0,        1);
    add(LW,  32'h0,    32'h0,        0, 0, 32'hDEADBEEF, 0);
    add(SB,  32'h21,   32'h00000005, 0, 0, 32'h0,        1);
    add(LW,  32'h20,   32'h0,        0, 0, 32'hCAFE05BE, 0);
    add(ALU, 32'h20,   32'h0,        0, 0, 32'h0,        0);
    add(LB,  32'h23,   32'h0,        0, 0, 32'hFFFFFFCA, 0);
    add(LBU, 32'h22,   32'h0,        0, 0, 32'h000000FE, 0);
    add(LHU, 32'h22,   32'h0,        0, 0, 32'h0000CAFE, 0);
    add(LH,  32'h23,   32'h0,        0, 0, 32'hFFFFCAFE, 0);
    add(SH,  32'h21,   32'h0000ABCD, 0, 0, 32'h0,        1);
    add(LW,  32'h20,   32'h0,        0, 0, 32'hCAFEABCD, 0);
    add(SW,  32'h30,   32'h01234567, 0, 0, 32'h0,        1);
    add(LW,  32'h30,   32'h0,        0, 0, 32'h01234567, 0);

    foreach (vecs[i]) begin
      instr = mk(vecs[i].op, i);
      drive_e(instr, vecs[i].addr, vecs[i].wd, 5'(i), 32'h400 + 32'(i) * 4);
      @(posedge clk); #1;
      ForwardRTM = vecs[i].fwd;
      MUXRFWDOut = vecs[i].mux;
      #1;
      chk($sformatf("v%0d_instr", i), Instr_M, instr);
      chk($sformatf("v%0d_alu", i), ALUOutput_M, vecs[i].addr);
      chk($sformatf("v%0d_rd", i), {27'h0, WriteRd_M}, 32'(i));
      chk($sformatf("v%0d_pc4", i), PCPlus4_M, 32'h400 + 32'(i) * 4);
      chk($sformatf("v%0d_rdata", i), ReadData_M, vecs[i].exp_rd);
      chk($sformatf("v%0d_mw", i), {31'h0, MemWrite_M}, {31'h0, vecs[i].exp_mw});
    end

    // Reset pulse while a store sits in M: store is dropped, outputs clear at once.
    drive_e(mk(SW, 'h30), 32'h30, 32'h5A5A5A5A, 5'd7, 32'h800);
    @(posedge clk); #1;
    ForwardRTM = 1'b0;
    #1;
    chk("mid_mw_before", {31'h0, MemWrite_M}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_instr_async", Instr_M, 32'h0);
    chk("mid_alu_async", ALUOutput_M, 32'h0);
    chk("mid_pc4_async", PCPlus4_M, 32'h0);
    chk("mid_rd_async", {27'h0, WriteRd_M}, 32'h0);
    chk("mid_mw_async", {31'h0, MemWrite_M}, 32'h0);
    reset = 1'b1;
    drive_e(mk(LW, 'h30), 32'h30, 32'h0, 5'd8, 32'h804);
    @(posedge clk); #1;
    chk("mid_lw_old", ReadData_M, 32'h01234567);
    chk("mid_lw_mw", {31'h0, MemWrite_M}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_m_stage.md
Name: pipeline_m_stage

Overview:
- Memory stage of the five-stage MIPS pipeline, directly downstream of the execute stage.
- Contains the E/M pipeline register, a word-organised data memory with byte/halfword store enables, and load alignment/extension logic.
- Also contains the M-stage store-data forwarding mux.
- Its outputs feed the M/W register and the hazard/forwarding unit.

Parameters:
- DM_DEPTH, 1024, number of 32-bit words in data memory; word index = ALUOutput_M[log2(DM_DEPTH)+1:2].

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Instr_E  input  32  instruction leaving E.
- ALUOutput_E  input  32  E-stage result: memory address or ALU/PC+8 value.
- WriteData_E  input  32  forwarded rt value from E (store data).
- WriteRd_E  input  5  destination register from E.
- PCPlus4_E  input  32  PC+4 of the E instruction.
- MUXRFWDOut  input  32  W-stage writeback value, used for store-data forwarding.
- ForwardRTM  input  1  0 = registered store data; 1 = MUXRFWDOut.
- Instr_M  output  32  registered instruction.
- ALUOutput_M  output  32  registered address/result; also the E/M forwarding source.
- WriteRd_M  output  5  registered destination register.
- PCPlus4_M  output  32  registered PC+4.
- ReadData_M  output  32  aligned and extended load data, combinational.
- MemWrite_M  output  1  high while a store occupies M; for debug and the bench.

Behaviour:
- E/M register: on posedge clk, captures Instr, ALUOutput, WriteData, WriteRd and PCPlus4 from E. There is no stall and no flush input; a new value is captured every cycle.
- When reset is low, all register outputs clear to 0 immediately and asynchronously. Instr_M = 0 decodes as a nop (sll $0), so no store occurs.
- Data memory contents are not cleared by reset and hold through reset.
- Opcode decode on Instr_M[31:26]:
  - lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - sw 101011, sh 101001, sb 101000.
  - Any other opcode: no memory access, ReadData_M = 0.
- Store data SD = ForwardRTM ? MUXRFWDOut : WriteData_M(reg). Forwarding covers a load in W followed by a store in M using the loaded register.
- Address: word index = ALUOutput_M[log2(DM_DEPTH)+1:2]. Upper bits are ignored, so the index wraps modulo DM_DEPTH.
- Memory read is asynchronous/combinational on the word index. Memory write commits at the posedge that ends the store's M cycle.
- Store byte enables:
  - sw: all 4 bytes; addr[1:0] ignored.
  - sh: addr[1]=0 writes bytes 1:0 with SD[15:0]; addr[1]=1 writes bytes 3:2 with SD[15:0]. addr[0] ignored.
  - sb: byte addr[1:0] written with SD[7:0]. Other bytes of the word are unchanged.
- MemWrite_M = 1 for sw/sh/sb, otherwise 0; reset value 0.
- Load extraction from word W:
  - lw: W.
  - lh/lhu: halfword chosen by addr[1], then sign/zero extended.
  - lb/lbu: byte chosen by addr[1:0], then sign/zero extended.
- Misaligned accesses raise no exception; they are handled by the truncation rules above.
- Latency: an instruction is visible on the M outputs 1 cycle after it is presented on the E inputs. A load's data is valid in that same cycle. A store is visible to a following load 1 cycle later (the next instruction in M).
- Reset asserted mid-store: if reset falls before the write edge, the pending store is dropped, because Instr_M is cleared. Reset release has no effect until the next posedge.

Test Plan:
- Reset: hold reset low, drive random E inputs -> all M outputs 0, MemWrite_M = 0. Release reset, present sw -> MemWrite_M = 1 one cycle later.
- sw $t,0x10 with WriteData_E = 0x8899AABB, then lw 0x10 -> ReadData_M = 0x8899AABB. Follow with lb 0x13 -> 0xFFFFFF88, and lbu 0x11 -> 0x000000AA.
- sh at 0x12 with data 0x0000_1234 over word 0xFFFFFFFF, then lw 0x10 -> 0x1234FFFF. lh 0x12 -> 0x00001234. sb 0x10 of 0x7F, then lw -> 0x1234FF7F.
- Store forwarding: WriteData_E = 0x11111111, ForwardRTM = 1, MUXRFWDOut = 0xCAFEBABE, sw 0x20 -> lw 0x20 returns 0xCAFEBABE.
- Wrap: DM_DEPTH = 1024, sw to 0x00001000 with 0xDEADBEEF -> lw 0x00000000 returns 0xDEADBEEF.
- Reset mid-store: sw 0x30 of 0x5A5A5A5A in M, pulse reset low before the posedge -> lw 0x30 returns the previous contents; pipeline outputs return to 0 asynchronously.
